// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types and field widths for the RTC access scheduler
package rtc_pkg;

  localparam int TIME_W = 24;
  localparam int DATE_W = 32;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_TIME,
    OP_DATE,
    OP_READ
  } op_t;

endpackage

// File: rtl/rtc_poll_timer.sv
// rtl/rtc_poll_timer.sv - free-running poll period counter with a one-cycle tick
module rtc_poll_timer #(
  parameter int unsigned POLL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  logic [31:0] cnt;

  assign tick = (cnt == 32'(POLL_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/rtc_access_sched.sv
// rtl/rtc_access_sched.sv - arbitrates set-time/set-date requests and periodic reads
// onto the PCF8563 controller and latches the last read time/date
module rtc_access_sched
  import rtc_pkg::*;
#(
  parameter int unsigned POLL_CYCLES    = 50_000_000,
  parameter int unsigned STARTUP_CYCLES = 100_000,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_set_time,
  input  logic [TIME_W-1:0] req_time,
  input  logic              req_set_date,
  input  logic [DATE_W-1:0] req_date,
  output logic              cmd_set_time,
  output logic [TIME_W-1:0] cmd_time,
  output logic              cmd_set_date,
  output logic [DATE_W-1:0] cmd_date,
  output logic              cmd_read,
  input  logic              ctrl_set_done,
  input  logic              ctrl_read_done,
  input  logic [TIME_W-1:0] ctrl_time,
  input  logic [DATE_W-1:0] ctrl_date,
  output logic [TIME_W-1:0] rtc_time,
  output logic [DATE_W-1:0] rtc_date,
  output logic              rtc_valid,
  output logic              rtc_update,
  output logic              set_ack,
  output logic              busy,
  output logic              timeout_err
);

  state_t            state;
  op_t               op;
  logic [31:0]       cnt;
  logic              pend_time, pend_date, pend_read;
  logic [TIME_W-1:0] hold_time;
  logic [DATE_W-1:0] hold_date;
  logic              poll_tick;
  logic              take_date, take_time, take_read;
  logic              set_done_ok, read_done_ok;

  rtc_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_poll_timer (
    .clk (clk),
    .rstn(rstn),
    .tick(poll_tick)
  );

  // Fixed priority: date, then time, then read-back.
  always_comb begin
    take_date    = 1'b0;
    take_time    = 1'b0;
    take_read    = 1'b0;
    set_done_ok  = 1'b0;
    read_done_ok = 1'b0;
    if (state == ST_IDLE) begin
      take_date = pend_date;
      take_time = !pend_date && pend_time;
      take_read = !pend_date && !pend_time && pend_read;
    end
    if (state == ST_WAIT) begin
      set_done_ok  = ctrl_set_done && (op == OP_TIME || op == OP_DATE);
      read_done_ok = ctrl_read_done && (op == OP_READ);
    end
  end

  // A new request arriving in the consuming cycle keeps its flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_time <= 1'b0;
      pend_date <= 1'b0;
      pend_read <= 1'b0;
      hold_time <= '0;
      hold_date <= '0;
    end else begin
      if (req_set_time) begin
        pend_time <= 1'b1;
        hold_time <= req_time;
      end else if (take_time) begin
        pend_time <= 1'b0;
      end
      if (req_set_date) begin
        pend_date <= 1'b1;
        hold_date <= req_date;
      end else if (take_date) begin
        pend_date <= 1'b0;
      end
      if (poll_tick || set_done_ok) begin
        pend_read <= 1'b1;
      end else if (take_read) begin
        pend_read <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_STARTUP;
      op           <= OP_NONE;
      cnt          <= '0;
      cmd_set_time <= 1'b0;
      cmd_set_date <= 1'b0;
      cmd_read     <= 1'b0;
      cmd_time     <= '0;
      cmd_date     <= '0;
      rtc_time     <= '0;
      rtc_date     <= '0;
      rtc_valid    <= 1'b0;
      rtc_update   <= 1'b0;
      set_ack      <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      cmd_set_time <= 1'b0;
      cmd_set_date <= 1'b0;
      cmd_read     <= 1'b0;
      rtc_update   <= 1'b0;
      set_ack      <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        ST_STARTUP: begin
          if (cnt == 32'(STARTUP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt  <= cnt + 32'd1;
            busy <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (take_date) begin
            op       <= OP_DATE;
            cmd_date <= hold_date;
            state    <= ST_ISSUE;
            busy     <= 1'b1;
          end else if (take_time) begin
            op       <= OP_TIME;
            cmd_time <= hold_time;
            state    <= ST_ISSUE;
            busy     <= 1'b1;
          end else if (take_read) begin
            op    <= OP_READ;
            state <= ST_ISSUE;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_ISSUE: begin
          cmd_set_time <= (op == OP_TIME);
          cmd_set_date <= (op == OP_DATE);
          cmd_read     <= (op == OP_READ);
          cnt          <= '0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (set_done_ok) begin
            set_ack <= 1'b1;
            op      <= OP_NONE;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end else if (read_done_ok) begin
            rtc_time   <= ctrl_time;
            rtc_date   <= ctrl_date;
            rtc_update <= 1'b1;
            rtc_valid  <= 1'b1;
            op         <= OP_NONE;
            state      <= ST_IDLE;
            busy       <= 1'b0;
          end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            op          <= OP_NONE;
            state       <= ST_IDLE;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= ST_STARTUP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_access_sched.sv
// tb/tb_rtc_access_sched.sv - directed bench for rtc_access_sched with a
// controller model that answers each command 10 cycles later
module tb_rtc_access_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_set_time = 1'b0;
  logic [23:0] req_time = '0;
  logic        req_set_date = 1'b0;
  logic [31:0] req_date = '0;
  logic        cmd_set_time, cmd_set_date, cmd_read;
  logic [23:0] cmd_time;
  logic [31:0] cmd_date;
  logic        ctrl_set_done = 1'b0;
  logic        ctrl_read_done = 1'b0;
  logic [23:0] ctrl_time = 24'h123456;
  logic [31:0] ctrl_date = 32'h24010101;
  logic [23:0] rtc_time;
  logic [31:0] rtc_date;
  logic        rtc_valid, rtc_update, set_ack, busy, timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_cst, n_csd, n_crd, n_ack, n_upd, n_to;
  int t_cst, t_csd, t_crd, t_ack, t_upd, t_to;
  logic [23:0] v_cmd_time;
  logic [31:0] v_cmd_date;

  int   model_cnt = 0;
  logic model_is_read = 1'b0;
  logic answer_reads = 1'b1;

  rtc_access_sched #(
    .POLL_CYCLES(100),
    .STARTUP_CYCLES(20),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_set_time(req_set_time), .req_time(req_time),
    .req_set_date(req_set_date), .req_date(req_date),
    .cmd_set_time(cmd_set_time), .cmd_time(cmd_time),
    .cmd_set_date(cmd_set_date), .cmd_date(cmd_date),
    .cmd_read(cmd_read),
    .ctrl_set_done(ctrl_set_done), .ctrl_read_done(ctrl_read_done),
    .ctrl_time(ctrl_time), .ctrl_date(ctrl_date),
    .rtc_time(rtc_time), .rtc_date(rtc_date), .rtc_valid(rtc_valid),
    .rtc_update(rtc_update), .set_ack(set_ack), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Controller model: done is visible at the 11th rising edge after the command edge.
  always @(negedge clk) begin
    ctrl_set_done  = 1'b0;
    ctrl_read_done = 1'b0;
    if (!rstn) begin
      model_cnt = 0;
    end else begin
      if (model_cnt != 0) begin
        model_cnt = model_cnt - 1;
        if (model_cnt == 0) begin
          if (model_is_read) ctrl_read_done = answer_reads;
          else ctrl_set_done = 1'b1;
        end
      end
      if (cmd_read) begin
        model_cnt = 10;
        model_is_read = 1'b1;
      end
      if (cmd_set_time || cmd_set_date) begin
        model_cnt = 10;
        model_is_read = 1'b0;
      end
    end
  end

  task automatic clear_log();
    n_cst = 0; n_csd = 0; n_crd = 0; n_ack = 0; n_upd = 0; n_to = 0;
    t_cst = 0; t_csd = 0; t_crd = 0; t_ack = 0; t_upd = 0; t_to = 0;
    v_cmd_time = '0; v_cmd_date = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cmd_set_time) begin n_cst++; t_cst = cyc; v_cmd_time = cmd_time; end
    if (cmd_set_date) begin n_csd++; t_csd = cyc; v_cmd_date = cmd_date; end
    if (cmd_read)     begin n_crd++; t_crd = cyc; end
    if (set_ack)      begin n_ack++; t_ack = cyc; end
    if (rtc_update)   begin n_upd++; t_upd = cyc; end
    if (timeout_err)  begin n_to++;  t_to = cyc; end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_set_time = 1'b0;
    req_set_date = 1'b0;
    answer_reads = 1'b1;
    ctrl_time = 24'h123456;
    ctrl_date = 32'h24010101;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc = 0;
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cmd_set_time, cmd_set_date, cmd_read, set_ack, rtc_update, timeout_err, busy, rtc_valid} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000000",
               {cmd_set_time, cmd_set_date, cmd_read, set_ack, rtc_update, timeout_err, busy, rtc_valid});
    end
    checks++;
    if ({cmd_time, cmd_date, rtc_time, rtc_date} !== 112'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {cmd_time, cmd_date, rtc_time, rtc_date});
    end
    run_to(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL startup_busy got %b want 1", busy); end
    run_to(101);
    checks++;
    if (n_cst + n_csd + n_crd !== 0) begin
      errors++; $display("FAIL no_cmd_before_poll got %0d want 0", n_cst + n_csd + n_crd);
    end
    run_to(102);
    checks++;
    if (n_crd !== 1 || t_crd !== 102) begin
      errors++; $display("FAIL first_poll_read got n=%0d t=%0d want n=1 t=102", n_crd, t_crd);
    end
    run_to(112);
    checks++;
    if (rtc_valid !== 1'b0) begin errors++; $display("FAIL valid_before_done got %b want 0", rtc_valid); end
    run_to(113);
    checks++;
    if (n_upd !== 1 || t_upd !== 113) begin
      errors++; $display("FAIL first_update got n=%0d t=%0d want n=1 t=113", n_upd, t_upd);
    end
    checks++;
    if (rtc_time !== 24'h123456 || rtc_date !== 32'h24010101 || rtc_valid !== 1'b1) begin
      errors++; $display("FAIL first_read_data got %h %h %b want 123456 24010101 1", rtc_time, rtc_date, rtc_valid);
    end
    run_to(114);
    checks++;
    if (rtc_update !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL update_pulse_end got upd=%b busy=%b want 0 0", rtc_update, busy);
    end
  endtask

  task automatic test_set_time_startup();
    do_reset();
    run_to(4);
    req_set_time = 1'b1;
    req_time = 24'h235959;
    step();
    req_set_time = 1'b0;
    req_time = 24'h000000;
    run_to(22);
    checks++;
    if (n_cst !== 1 || t_cst !== 22 || v_cmd_time !== 24'h235959) begin
      errors++; $display("FAIL startup_set_time got n=%0d t=%0d d=%h want n=1 t=22 d=235959", n_cst, t_cst, v_cmd_time);
    end
    run_to(33);
    checks++;
    if (n_ack !== 1 || t_ack !== 33) begin
      errors++; $display("FAIL startup_set_ack got n=%0d t=%0d want n=1 t=33", n_ack, t_ack);
    end
    run_to(35);
    checks++;
    if (n_crd !== 1 || t_crd !== 35) begin
      errors++; $display("FAIL readback_after_set got n=%0d t=%0d want n=1 t=35", n_crd, t_crd);
    end
    run_to(46);
    checks++;
    if (n_upd !== 1 || t_upd !== 46 || cmd_time !== 24'h235959) begin
      errors++; $display("FAIL readback_update got n=%0d t=%0d cmd_time=%h want n=1 t=46 235959", n_upd, t_upd, cmd_time);
    end
  endtask

  task automatic test_same_cycle_set();
    do_reset();
    run_to(29);
    req_set_time = 1'b1;
    req_time = 24'h101010;
    req_set_date = 1'b1;
    req_date = 32'h24061503;
    step();
    req_set_time = 1'b0;
    req_set_date = 1'b0;
    run_to(32);
    checks++;
    if (n_csd !== 1 || t_csd !== 32 || v_cmd_date !== 32'h24061503 || n_cst !== 0) begin
      errors++; $display("FAIL date_first got n=%0d t=%0d d=%h tn=%0d want n=1 t=32 d=24061503 tn=0", n_csd, t_csd, v_cmd_date, n_cst);
    end
    run_to(45);
    checks++;
    if (n_ack !== 1 || t_ack !== 43) begin
      errors++; $display("FAIL date_ack got n=%0d t=%0d want n=1 t=43", n_ack, t_ack);
    end
    checks++;
    if (n_cst !== 1 || t_cst !== 45 || v_cmd_time !== 24'h101010 || n_crd !== 0) begin
      errors++; $display("FAIL time_second got n=%0d t=%0d d=%h rn=%0d want n=1 t=45 d=101010 rn=0", n_cst, t_cst, v_cmd_time, n_crd);
    end
    run_to(58);
    checks++;
    if (n_ack !== 2 || t_ack !== 56 || n_crd !== 1 || t_crd !== 58) begin
      errors++; $display("FAIL read_last got ack=%0d@%0d rd=%0d@%0d want 2@56 1@58", n_ack, t_ack, n_crd, t_crd);
    end
    run_to(70);
    checks++;
    if (n_ack !== 2 || n_upd !== 1 || t_upd !== 69) begin
      errors++; $display("FAIL same_cycle_tail got ack=%0d upd=%0d@%0d want 2 1@69", n_ack, n_upd, t_upd);
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    run_to(104);
    checks++;
    if (busy !== 1'b1 || n_crd !== 1) begin
      errors++; $display("FAIL busy_in_wait got busy=%b rd=%0d want 1 1", busy, n_crd);
    end
    req_set_time = 1'b1;
    req_time = 24'h010203;
    step();
    req_set_time = 1'b0;
    run_to(107);
    req_set_time = 1'b1;
    req_time = 24'h040506;
    step();
    req_set_time = 1'b0;
    run_to(115);
    checks++;
    if (n_cst !== 1 || t_cst !== 115 || v_cmd_time !== 24'h040506) begin
      errors++; $display("FAIL latest_wins got n=%0d t=%0d d=%h want n=1 t=115 d=040506", n_cst, t_cst, v_cmd_time);
    end
    run_to(130);
    checks++;
    if (n_cst !== 1 || n_ack !== 1 || t_ack !== 126 || n_crd !== 2 || t_crd !== 128) begin
      errors++; $display("FAIL overwrite_tail got st=%0d ack=%0d@%0d rd=%0d@%0d want 1 1@126 2@128", n_cst, n_ack, t_ack, n_crd, t_crd);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_to(150);
    ctrl_time = 24'h654321;
    ctrl_date = 32'h99123106;
    answer_reads = 1'b0;
    run_to(202);
    checks++;
    if (n_crd !== 2 || t_crd !== 202) begin
      errors++; $display("FAIL second_poll got n=%0d t=%0d want n=2 t=202", n_crd, t_crd);
    end
    run_to(251);
    checks++;
    if (n_to !== 0) begin errors++; $display("FAIL early_timeout got %0d want 0", n_to); end
    run_to(252);
    checks++;
    if (n_to !== 1 || t_to !== 252 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse got n=%0d t=%0d busy=%b want n=1 t=252 busy=0", n_to, t_to, busy);
    end
    checks++;
    if (rtc_time !== 24'h123456 || rtc_date !== 32'h24010101 || rtc_valid !== 1'b1 || n_upd !== 1) begin
      errors++; $display("FAIL rtc_held got %h %h %b upd=%0d want 123456 24010101 1 1", rtc_time, rtc_date, rtc_valid, n_upd);
    end
    run_to(302);
    checks++;
    if (n_crd !== 3 || t_crd !== 302 || n_to !== 1) begin
      errors++; $display("FAIL retry_poll got rd=%0d@%0d to=%0d want 3@302 1", n_crd, t_crd, n_to);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    run_to(29);
    req_set_time = 1'b1;
    req_time = 24'h010101;
    step();
    req_set_time = 1'b0;
    run_to(33);
    req_set_date = 1'b1;
    req_date = 32'h11111111;
    step();
    req_set_date = 1'b0;
    run_to(35);
    checks++;
    if (n_cst !== 1 || t_cst !== 32 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_wait got n=%0d t=%0d busy=%b want 1 32 1", n_cst, t_cst, busy);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, cmd_time, cmd_date, rtc_time, rtc_date, rtc_valid, set_ack, timeout_err} !== 119'h0) begin
      errors++; $display("FAIL async_reset_outputs got busy=%b cmd_time=%h want all 0", busy, cmd_time);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc = 0;
    clear_log();
    run_to(101);
    checks++;
    if (n_cst + n_csd + n_crd !== 0) begin
      errors++; $display("FAIL pending_cleared got %0d cmds want 0", n_cst + n_csd + n_crd);
    end
    run_to(102);
    checks++;
    if (n_crd !== 1 || t_crd !== 102) begin
      errors++; $display("FAIL post_reset_poll got n=%0d t=%0d want n=1 t=102", n_crd, t_crd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_log();
    test_reset();
    test_set_time_startup();
    test_same_cycle_set();
    test_overwrite();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_access_sched.md
Name: rtc_access_sched

Overview:
- Schedules all accesses to the PCF8563 register controller.
- Shares the controller between UART-originated set-time and set-date requests and an internal periodic read poll.
- Holds the last read time/date in registers for display and UART readback.
- Sits between the UART command decoder and pcf8563_ctrl.
- pcf8563_ctrl samples its commands only while in its IDLE state. This block therefore issues single-cycle command pulses only after the startup window and only after the previous operation's done pulse.

Parameters:
- POLL_CYCLES, 50_000_000: clock cycles between periodic read polls (1 s at 50 MHz).
- STARTUP_CYCLES, 100_000: cycles after reset before the first command, so the controller's init write can complete.
- TIMEOUT_CYCLES, 5_000_000: maximum cycles to wait for set_done/read_done before aborting.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req_set_time  in  1  one-cycle request from UART decoder
- req_time  in  24  BCD {hour,min,sec} for req_set_time
- req_set_date  in  1  one-cycle request from UART decoder
- req_date  in  32  BCD {year,month,day,weekday} for req_set_date
- cmd_set_time  out  1  pulse to pcf8563_ctrl set_time
- cmd_time  out  24  to time_2_set
- cmd_set_date  out  1  pulse to pcf8563_ctrl set_date
- cmd_date  out  32  to date_2_set
- cmd_read  out  1  pulse to pcf8563_ctrl read
- ctrl_set_done  in  1  from set_done
- ctrl_read_done  in  1  from read_done
- ctrl_time  in  24  from time_read
- ctrl_date  in  32  from date_read
- rtc_time  out  24  latched time
- rtc_date  out  32  latched date
- rtc_valid  out  1  high after first successful read
- rtc_update  out  1  one-cycle pulse when rtc_time/rtc_date reload
- set_ack  out  1  one-cycle pulse when a set op completes
- busy  out  1  high outside IDLE
- timeout_err  out  1  one-cycle pulse on aborted op

Behaviour:
- Reset: all outputs 0. Pending flags 0, counters 0, FSM in STARTUP.
- Pending capture:
  - req_set_time sets pend_time and loads req_time into a holding register. req_set_date does the same for pend_date.
  - A repeat request while already pending overwrites the data (latest wins).
  - The poll counter counts to POLL_CYCLES-1, wraps, and sets pend_read.
  - A completed set also sets pend_read, so the new time is read back.
  - When a request arrives in the same cycle its flag is consumed, the set wins: the flag stays 1 with the new data.
- FSM states: STARTUP, IDLE, ISSUE, WAIT.
  - STARTUP: count STARTUP_CYCLES, then go to IDLE. Requests are captured but not issued; the poll counter runs.
  - IDLE: priority is pend_date > pend_time > pend_read. On any pending, latch the op type, clear that flag, load cmd_time/cmd_date from the holding register (set ops only), and go to ISSUE.
  - ISSUE: the matching cmd_* is high for exactly this one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT, set op: on ctrl_set_done, pulse set_ack, set pend_read, go to IDLE.
  - WAIT, read op: on ctrl_read_done, load rtc_time/rtc_date from ctrl_time/ctrl_date, pulse rtc_update, set rtc_valid, go to IDLE.
  - WAIT, wrong-type done pulses are ignored.
  - WAIT, timeout: when the counter reaches TIMEOUT_CYCLES-1, pulse timeout_err and go to IDLE. The op is dropped, not retried; a periodic read retries naturally.
- Latency: a request sampled at edge k in IDLE produces cmd_* high in the cycle after edge k+2. Done in WAIT returns to IDLE in 1 cycle, so back-to-back ops are spaced by at least 2 idle-to-issue cycles.
- cmd_time/cmd_date stay stable from ISSUE until the next set op.
- rtc_* hold their values through set ops and timeouts.
- Reset mid-operation: immediate return to reset values and STARTUP. pcf8563_ctrl shares rstn and re-inits.
- Counters are 32 bit unsigned. Parameters must be at least 2.

Decomposition:
- rtc_pkg: FSM state encodings, op-type encoding (OP_NONE/OP_TIME/OP_DATE/OP_READ), and the field widths TIME_W=24 and DATE_W=32.
- One sub-module is natural: rtc_poll_timer, a free-running POLL_CYCLES counter with a one-cycle tick output.
- Arbitration, FSM and result latching stay in rtc_access_sched.

Test Plan:
All scenarios use POLL_CYCLES=100, STARTUP_CYCLES=20, TIMEOUT_CYCLES=50, with a controller model that pulses done 10 cycles after a command.
- Reset, no requests: no cmd_* before cycle 20; first cmd_read at poll tick 100; rtc_valid=1 and rtc_update pulse after the model returns time 24'h123456.
- req_set_time at cycle 5 with 24'h235959: held through STARTUP; cmd_set_time issued at cycle 22 with cmd_time=24'h235959; then set_ack; then cmd_read issued automatically.
- req_set_date (32'h24061503) and req_set_time in the same cycle while IDLE: date issued first, time issued after set_done, read last; exactly one set_ack per op.
- Two req_set_time (24'h010203, then 24'h040506) while WAIT on a read: only 24'h040506 is issued.
- Model never answers a read: timeout_err pulses 50 cycles after ISSUE; rtc_* unchanged; the next poll issues cmd_read again.
- rstn low during WAIT: all outputs 0 the next cycle, FSM in STARTUP, pending flags cleared.
